deco4_16_sync: RTL and testbench
================================

// Module: deco4_16_sync
// PURPOSE
//   Registered 4-to-16 line decoder with enable. Converts a 4-bit binary code d
//   into a one-hot 16-bit word y; y[d] is asserted when enabled.
//   Used as an address/select decoder feeding chip-select or mux-select logic.
//   Output is registered on clk, with synchronous active-high reset.
// PARAMETERS
//   OUT_ACTIVE_LOW  0  0: selected line is 1, others 0. 1: y is inverted (selected line is 0, others 1).
//   REGISTER_OUT    1  1: y is updated one clk after the inputs. 0: y is combinational from d/en (rst still clears the enable register).
// PORTS
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous reset, active-high
//   y      out  16  decoded one-hot output (polarity per OUT_ACTIVE_LOW)
//   d      in   4   binary select code, d[3] = MSB
//   en     in   1   decode enable, active-high
//   valid  out  1   high when y currently reflects an enabled decode
// BEHAVIOUR
//   - Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
//   - Reset: on a clk edge with rst=1, y = 16'h0000 (16'hFFFF if OUT_ACTIVE_LOW) and valid = 0.
//     rst takes priority over en and d.
//   - Decode, active-high polarity:
//       en=1: y = 16'h0001 << d, so exactly one bit is set; valid = 1.
//       en=0: y = 16'h0000; valid = 0.
//   - Decode, OUT_ACTIVE_LOW=1: y is the bitwise inverse of the active-high value.
//   - Latency with REGISTER_OUT=1: inputs are sampled on the rising edge; y and valid
//     update on that edge, so latency is 1 cycle. Holding d and en holds y.
//   - Latency with REGISTER_OUT=0:
//       y and valid follow d and en combinationally.
//       While rst=1, y and valid are forced to their reset values.
//   - X/unknown inputs are not masked. All 16 codes are legal, so no error case exists.
//   - Simultaneous changes of d and en in one cycle: the next y reflects both new values.
//   - rst mid-operation:
//       The next edge clears y.
//       The first edge after rst deasserts decodes the d/en sampled at that edge.
//   - Invariant: popcount(y) == en after reset (active-high polarity); never more than one line set.
// TESTING
//   - rst=1 for 2 cycles with en=1, d=4'h5 -> y=16'h0000, valid=0. Release rst -> next edge y=16'h0020.
//   - en=0, sweep d=0..15 -> y stays 16'h0000 and valid=0 at every edge.
//   - en=1, step d 0..15 in order, one edge each:
//       each edge -> y = 1<<d, e.g. d=0 -> 16'h0001, d=9 -> 16'h0200, d=15 -> 16'h8000;
//       valid=1; y lags d by one cycle.
//   - en=1, d=4'hA, then drop en to 0 with d unchanged -> y goes 16'h0400 then 16'h0000.
//   - OUT_ACTIVE_LOW=1, en=1, d=3 -> y=16'hFFF7. en=0 -> 16'hFFFF. rst -> 16'hFFFF.
//   - Assert rst for one edge mid-sweep (d=7, en=1) -> y=0 that cycle. Next edge y=16'h0080.

Source files
------------

// File: rtl/deco4_16_sync.sv
// Registered 4-to-16 line decoder with enable, selectable output polarity and
// an optional combinational (unregistered) output path.
module deco4_16_sync #(
    parameter bit OUT_ACTIVE_LOW = 1'b0,
    parameter bit REGISTER_OUT   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] y,
    input  logic [3:0]  d,
    input  logic        en,
    output logic        valid
);

    localparam logic [15:0] IDLE_Y = OUT_ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    logic        next_valid;
    logic [15:0] next_hot;
    logic [15:0] next_y;
    logic        valid_q;
    logic [15:0] y_q;

    // Shared decode: rst forces the idle pattern so the combinational path
    // honours reset exactly like the registered one.
    always_comb begin
        next_valid = en & ~rst;
        next_hot   = 16'h0000;
        if (next_valid) begin
            next_hot = 16'h0001 << d;
        end
        next_y = OUT_ACTIVE_LOW ? ~next_hot : next_hot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= IDLE_Y;
        end else begin
            valid_q <= next_valid;
            y_q     <= next_y;
        end
    end

    // valid is a plain qualifier on y (no handshake): high exactly when y
    // carries an enabled decode.
    assign y     = REGISTER_OUT ? y_q     : next_y;
    assign valid = REGISTER_OUT ? valid_q : next_valid;

endmodule

// File: tb/tb_deco4_16_sync.sv
// Bench for deco4_16_sync: registered active-high, registered active-low and
// combinational instances driven in parallel and compared to a power-of-two model.
module tb_deco4_16_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [3:0]  d   = 4'h0;

    logic [15:0] y_reg, y_low, y_comb;
    logic        valid_reg, valid_low, valid_comb;

    int checks   = 0;
    int failures = 0;

    logic [15:0] prev_y;
    logic        prev_v;
    logic        have_prev = 1'b0;

    always #5 clk = ~clk;

    deco4_16_sync #(.OUT_ACTIVE_LOW(1'b0), .REGISTER_OUT(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .y(y_reg), .d(d), .en(en), .valid(valid_reg)
    );

    deco4_16_sync #(.OUT_ACTIVE_LOW(1'b1), .REGISTER_OUT(1'b1)) dut_low (
        .clk(clk), .rst(rst), .y(y_low), .d(d), .en(en), .valid(valid_low)
    );

    deco4_16_sync #(.OUT_ACTIVE_LOW(1'b0), .REGISTER_OUT(1'b0)) dut_comb (
        .clk(clk), .rst(rst), .y(y_comb), .d(d), .en(en), .valid(valid_comb)
    );

    // Reference: the selected line carries weight 2**d; nothing selected when
    // disabled or in reset; active-low output is the complement.
    function automatic logic [15:0] model_y(input logic r, input logic e,
                                            input logic [3:0] dd, input logic low);
        int unsigned weight;
        logic [15:0] hot;
        weight = 1;
        for (int k = 0; k < int'(dd); k++) weight = weight * 2;
        hot = (r || !e) ? 16'h0000 : weight[15:0];
        return low ? ~hot : hot;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] dd);
        logic [15:0] ey;
        logic        ev;
        @(negedge clk);
        rst = r;
        en  = e;
        d   = dd;
        ev  = !r && e;
        #1;
        // Registered outputs must still show the previous decode.
        if (have_prev) begin
            chk("lag_y", y_reg, prev_y);
            chk("lag_valid", {15'b0, valid_reg}, {15'b0, prev_v});
        end
        chk("comb_y", y_comb, model_y(r, e, dd, 1'b0));
        chk("comb_valid", {15'b0, valid_comb}, {15'b0, ev});
        @(posedge clk);
        #1;
        ey = model_y(r, e, dd, 1'b0);
        chk("reg_y", y_reg, ey);
        chk("reg_valid", {15'b0, valid_reg}, {15'b0, ev});
        chk("low_y", y_low, model_y(r, e, dd, 1'b1));
        chk("low_valid", {15'b0, valid_low}, {15'b0, ev});
        prev_y    = ey;
        prev_v    = ev;
        have_prev = 1'b1;
    endtask

    initial begin
        // Reset held two edges with an enabled code on the inputs.
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'h5);
        chk("reset_y_const", y_reg, 16'h0000);
        chk("reset_low_const", y_low, 16'hFFFF);
        step(1'b0, 1'b1, 4'h5);
        chk("release_y_const", y_reg, 16'h0020);

        // Disabled sweep.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'(i));

        // Enabled sweep with spot checks on known constants.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 4'(i));
            if (i == 0)  chk("sweep_d0", y_reg, 16'h0001);
            if (i == 9)  chk("sweep_d9", y_reg, 16'h0200);
            if (i == 15) chk("sweep_d15", y_reg, 16'h8000);
        end

        // Drop enable with the code held.
        step(1'b0, 1'b1, 4'hA);
        chk("hold_a", y_reg, 16'h0400);
        step(1'b0, 1'b0, 4'hA);
        chk("drop_en", y_reg, 16'h0000);

        // Active-low constants.
        step(1'b0, 1'b1, 4'h3);
        chk("low_d3", y_low, 16'hFFF7);
        step(1'b0, 1'b0, 4'h3);
        chk("low_dis", y_low, 16'hFFFF);

        // Reset pulse in the middle of an enabled sequence.
        step(1'b0, 1'b1, 4'h6);
        step(1'b1, 1'b1, 4'h7);
        chk("mid_rst", y_reg, 16'h0000);
        step(1'b0, 1'b1, 4'h7);
        chk("after_rst", y_reg, 16'h0080);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
